// File: rtl/alu_seq_unit_if.sv
// Issue/writeback handshake bundle for alu_seq_unit.
// Carries operands and opcode toward the unit, and the registered result and flags back.
interface alu_seq_unit_if #(
  parameter int Width = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [Width-1:0] A;
  logic [Width-1:0] B;
  logic             Cin;
  logic [4:0]       F;
  logic             out_valid;
  logic             out_ready;
  logic [Width-1:0] Out;
  logic [5:0]       Status;

  modport master (
    output in_valid, A, B, Cin, F, out_ready,
    input  in_ready, out_valid, Out, Status
  );

  modport slave (
    input  in_valid, A, B, Cin, F, out_ready,
    output in_ready, out_valid, Out, Status
  );
endinterface

// File: rtl/alu_seq_unit.sv
// Handshaked ALU with registered result/flags, shift-add multiply and optional restoring divide.
// Define ALU_SEQ_DIV_EN to build the divider for F=18/19; otherwise those opcodes are illegal.
module alu_seq_unit #(
  parameter  int Width   = 16,
  localparam int SHAMT_W = $clog2(Width)
) (
  input logic           clk,
  input logic           rst,
  alu_seq_unit_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;
  typedef enum logic [1:0] {IT_MULLO, IT_MULHI, IT_DIV, IT_MOD} iter_op_t;

  state_t             state_q, state_n;
  iter_op_t           op_q;
  logic [Width-1:0]   hi_q, lo_q, opd_q, out_q;
  logic [5:0]         status_q;
  logic [SHAMT_W-1:0] cnt_q;

  logic               accept, start_iter, res_we;
  logic [Width-1:0]   hi_n, lo_n, res_out;
  logic [5:0]         res_status;

  logic [Width-1:0]   sc_out, opb;
  logic               sc_c, sc_v, sc_e;
  logic [Width:0]     sum_w, shw, mul_w;
  logic [2*Width-1:0] rot_w;
  logic [SHAMT_W-1:0] sh, rot_amt;

  // Status layout: {E, P, V, N, Z, C}; P is set when Out holds an even number of ones.
  function automatic logic [5:0] pack_flags(input logic [Width-1:0] o,
                                            input logic c, input logic v, input logic e);
    return {e, ~^o, v, o[Width-1], ~|o, c};
  endfunction

  assign bus.in_ready  = (state_q == S_IDLE) && !rst;
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.Out       = out_q;
  assign bus.Status    = status_q;
  assign accept        = bus.in_valid && bus.in_ready;

`ifdef ALU_SEQ_DIV_EN
  // A zero divisor finishes in one cycle through the single-cycle path.
  assign start_iter = accept && (bus.F[4:2] == 3'b100) && (!bus.F[1] || (bus.B != '0));
`else
  assign start_iter = accept && (bus.F[4:1] == 4'b1000);
`endif

  // Single-cycle datapath, evaluated on the live inputs and captured on accept.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch behind.
    sc_out  = '0;
    sc_c    = 1'b0;
    sc_v    = 1'b0;
    sc_e    = 1'b0;
    opb     = bus.B;
    sum_w   = '0;
    shw     = '0;
    rot_w   = '0;
    sh      = bus.B[SHAMT_W-1:0];
    rot_amt = SHAMT_W'(32'(sh) % 32'(Width));
    case (bus.F)
      5'd0, 5'd1, 5'd13: begin
        if (bus.F == 5'd13) opb = Width'(1);
        sum_w  = {1'b0, bus.A} + {1'b0, opb} + {{Width{1'b0}}, bus.Cin & (bus.F == 5'd1)};
        sc_out = sum_w[Width-1:0];
        sc_c   = sum_w[Width];
        sc_v   = (bus.A[Width-1] == opb[Width-1]) && (sum_w[Width-1] != bus.A[Width-1]);
      end
      5'd2, 5'd3, 5'd14: begin
        if (bus.F == 5'd14) opb = Width'(1);
        sum_w  = {1'b0, bus.A} - {1'b0, opb} - {{Width{1'b0}}, bus.Cin & (bus.F == 5'd3)};
        sc_out = sum_w[Width-1:0];
        sc_c   = sum_w[Width];
        sc_v   = (bus.A[Width-1] != opb[Width-1]) && (sum_w[Width-1] != bus.A[Width-1]);
      end
      5'd4:  sc_out = bus.A & bus.B;
      5'd5:  sc_out = bus.A | bus.B;
      5'd6:  sc_out = bus.A ^ bus.B;
      5'd7:  sc_out = ~bus.A;
      // Shifts carry one guard bit so the last bit shifted out lands in a fixed position.
      5'd8: begin
        shw    = {1'b0, bus.A} << sh;
        sc_out = shw[Width-1:0];
        sc_c   = shw[Width];
      end
      5'd9: begin
        shw    = {bus.A, 1'b0} >> sh;
        sc_out = shw[Width:1];
        sc_c   = shw[0];
      end
      5'd10: begin
        shw    = $signed({bus.A, 1'b0}) >>> sh;
        sc_out = shw[Width:1];
        sc_c   = shw[0];
      end
      5'd11: begin
        rot_w  = {bus.A, bus.A} << rot_amt;
        sc_out = rot_w[2*Width-1:Width];
        sc_c   = (sh != '0) && sc_out[0];
      end
      5'd12: begin
        rot_w  = {bus.A, bus.A} >> rot_amt;
        sc_out = rot_w[Width-1:0];
        sc_c   = (sh != '0) && sc_out[Width-1];
      end
      5'd15: sc_out = bus.B;
`ifdef ALU_SEQ_DIV_EN
      5'd18: begin
        sc_out = '1;
        sc_e   = 1'b1;
      end
      5'd19: begin
        sc_out = bus.A;
        sc_e   = 1'b1;
      end
`endif
      default: sc_e = 1'b1;
    endcase
  end

  // One iteration step: shift-add for multiply, restore-on-negative for divide.
  always_comb begin
    hi_n  = hi_q;
    lo_n  = lo_q;
    mul_w = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opd_q} : '0);
    if (op_q inside {IT_MULLO, IT_MULHI}) begin
      hi_n = mul_w[Width:1];
      lo_n = {mul_w[0], lo_q[Width-1:1]};
    end
`ifdef ALU_SEQ_DIV_EN
    else begin : div_step
      logic [Width:0] trial, diff;
      trial = {hi_q, lo_q[Width-1]};
      diff  = trial - {1'b0, opd_q};
      if (!diff[Width]) begin
        hi_n = diff[Width-1:0];
        lo_n = {lo_q[Width-2:0], 1'b1};
      end else begin
        hi_n = trial[Width-1:0];
        lo_n = {lo_q[Width-2:0], 1'b0};
      end
    end
`endif
  end

  always_comb begin
    state_n    = state_q;
    res_we     = 1'b0;
    res_out    = out_q;
    res_status = status_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (start_iter) begin
            state_n = S_CALC;
          end else begin
            state_n    = S_DONE;
            res_we     = 1'b1;
            res_out    = sc_out;
            res_status = pack_flags(sc_out, sc_c, sc_v, sc_e);
          end
        end
      end
      S_CALC: begin
        if (cnt_q == '0) begin
          state_n = S_DONE;
          res_we  = 1'b1;
          case (op_q)
            IT_MULLO: begin
              res_out    = lo_n;
              res_status = pack_flags(lo_n, |hi_n, |hi_n, 1'b0);
            end
            IT_MULHI: begin
              res_out    = hi_n;
              res_status = pack_flags(hi_n, 1'b0, 1'b0, 1'b0);
            end
`ifdef ALU_SEQ_DIV_EN
            IT_DIV: begin
              res_out    = lo_n;
              res_status = pack_flags(lo_n, 1'b0, 1'b0, 1'b0);
            end
            IT_MOD: begin
              res_out    = hi_n;
              res_status = pack_flags(hi_n, 1'b0, 1'b0, 1'b0);
            end
`endif
            default: res_we = 1'b1;
          endcase
        end
      end
      S_DONE: begin
        if (bus.out_valid && bus.out_ready) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: registers are updated with <= so every flop samples pre-edge values.
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_n;
  end

  // Reset clears the accumulators too, so an interrupted iteration leaves nothing behind.
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q     <= '0;
      lo_q     <= '0;
      opd_q    <= '0;
      op_q     <= IT_MULLO;
      cnt_q    <= '0;
      out_q    <= '0;
      status_q <= '0;
    end else begin
      if (start_iter) begin
        hi_q  <= '0;
        lo_q  <= bus.F[1] ? bus.A : bus.B;
        opd_q <= bus.F[1] ? bus.B : bus.A;
        op_q  <= iter_op_t'(bus.F[1:0]);
        cnt_q <= SHAMT_W'(Width - 1);
      end else if (state_q == S_CALC) begin
        hi_q  <= hi_n;
        lo_q  <= lo_n;
        cnt_q <= cnt_q - SHAMT_W'(1);
      end
      if (res_we) begin
        out_q    <= res_out;
        status_q <= res_status;
      end
    end
  end

endmodule

// File: tb/tb_alu_seq_unit.sv
// Directed and pseudo-random checks of alu_seq_unit at Width=16 against a scoreboard.
// Expectations for F=18/19 follow ALU_SEQ_DIV_EN as the RTL is built.
module tb_alu_seq_unit;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;

  alu_seq_unit_if #(.Width(W)) bus ();
  alu_seq_unit #(.Width(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    string          tag;
    logic [W-1:0]   out;
    logic [5:0]     st;
    int             lat;
  } exp_t;

  exp_t sb[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input string t, input logic [W-1:0] o, input logic [5:0] s,
                              input int l);
    exp_t r;
    r.tag = t; r.out = o; r.st = s; r.lat = l;
    return r;
  endfunction

  // Reference model built on integer arithmetic and bit-by-bit shifting.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic cin, input logic [4:0] f);
    exp_t         r;
    logic [W-1:0] o;
    logic         c, v, e;
    logic [2*W-1:0] p;
    int ua, ub, sa, sbv, ci, us, ss, s;
    c = 1'b0; v = 1'b0; e = 1'b0; o = '0; r.lat = 1;
    ua = int'(a); sa = int'($signed(a)); s = int'(b[3:0]);
    ub = (f == 5'd13 || f == 5'd14) ? 1 : int'(b);
    sbv = (f == 5'd13 || f == 5'd14) ? 1 : int'($signed(b));
    ci = ((f == 5'd1 || f == 5'd3) && cin) ? 1 : 0;
    p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    case (f)
      5'd0, 5'd1, 5'd13: begin
        us = ua + ub + ci; ss = sa + sbv + ci;
        o = W'(us); c = (us > 65535); v = (ss > 32767) || (ss < -32768);
      end
      5'd2, 5'd3, 5'd14: begin
        us = ua - ub - ci; ss = sa - sbv - ci;
        o = W'(us); c = (us < 0); v = (ss > 32767) || (ss < -32768);
      end
      5'd4: o = a & b;
      5'd5: o = a | b;
      5'd6: o = a ^ b;
      5'd7: o = ~a;
      5'd8, 5'd9, 5'd10, 5'd11, 5'd12: begin
        o = a;
        for (int k = 0; k < s; k++) begin
          case (f)
            5'd8:    begin c = o[W-1]; o = {o[W-2:0], 1'b0}; end
            5'd9:    begin c = o[0];   o = {1'b0, o[W-1:1]}; end
            5'd10:   begin c = o[0];   o = {o[W-1], o[W-1:1]}; end
            5'd11:   begin c = o[W-1]; o = {o[W-2:0], o[W-1]}; end
            default: begin c = o[0];   o = {o[0], o[W-1:1]}; end
          endcase
        end
      end
      5'd15: o = b;
      5'd16: begin o = p[W-1:0]; c = |p[2*W-1:W]; v = c; r.lat = W + 1; end
      5'd17: begin o = p[2*W-1:W]; r.lat = W + 1; end
`ifdef ALU_SEQ_DIV_EN
      5'd18: begin
        if (b == '0) begin o = '1; e = 1'b1; end
        else begin o = a / b; r.lat = W + 1; end
      end
      5'd19: begin
        if (b == '0) begin o = a; e = 1'b1; end
        else begin o = a % b; r.lat = W + 1; end
      end
`endif
      default: e = 1'b1;
    endcase
    r.out = o;
    r.st  = {e, ~^o, v, o[W-1], (o == '0), c};
    r.tag = "model";
    return r;
  endfunction

  // Drive one operation, wait (bounded) for accept, scramble inputs, push the expectation.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                       input logic [4:0] f, input exp_t x);
    int   n = 0;
    logic took = 1'b0;
    bus.A = a; bus.B = b; bus.Cin = cin; bus.F = f; bus.in_valid = 1'b1;
    while (!took && n < 50) begin
      took = bus.in_ready;
      @(posedge clk); #1;
      n++;
    end
    bus.in_valid = 1'b0;
    bus.A = ~a; bus.B = ~b; bus.Cin = ~cin; bus.F = ~f;
    check({x.tag, "/accept"}, 64'(took), 64'(1));
    sb.push_back(x);
  endtask

  // Wait (bounded) for out_valid, pop the scoreboard and compare; optionally hand off.
  task automatic collect(input bit handshake);
    int   lat = 1;
    exp_t x;
    while (!bus.out_valid && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
    x = sb.pop_front();
    check({x.tag, "/valid"}, 64'(bus.out_valid), 64'(1));
    check({x.tag, "/latency"}, 64'(lat), 64'(x.lat));
    check({x.tag, "/out"}, 64'(bus.Out), 64'(x.out));
    check({x.tag, "/status"}, 64'(bus.Status), 64'(x.st));
    if (handshake) begin
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid = 1'b0; bus.A = '0; bus.B = '0; bus.Cin = 1'b0; bus.F = '0;
    bus.out_ready = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset/out_valid", 64'(bus.out_valid), 64'(0));
    check("reset/in_ready", 64'(bus.in_ready), 64'(0));
    check("reset/out", 64'(bus.Out), 64'(0));
    check("reset/status", 64'(bus.Status), 64'(0));
    rst = 1'b0;
    #1;
    check("reset/in_ready_release", 64'(bus.in_ready), 64'(1));

    issue(16'hFFFF, 16'h0001, 1'b0, 5'd0, mk("add_wrap", 16'h0000, 6'h13, 1));  collect(1'b1);
    issue(16'h8000, 16'h0001, 1'b0, 5'd2, mk("sub_ovf", 16'h7FFF, 6'h08, 1));   collect(1'b1);
    issue(16'h0000, 16'h0000, 1'b1, 5'd3, mk("sbb_borrow", 16'hFFFF, 6'h15, 1)); collect(1'b1);
    issue(16'h0100, 16'h0100, 1'b0, 5'd16, mk("mullo", 16'h0000, 6'h1B, 17));   collect(1'b1);
    issue(16'h0100, 16'h0100, 1'b0, 5'd17, mk("mulhi", 16'h0001, 6'h00, 17));   collect(1'b1);
`ifdef ALU_SEQ_DIV_EN
    issue(16'd100, 16'd7, 1'b0, 5'd18, mk("div", 16'd14, 6'h00, 17));           collect(1'b1);
    issue(16'd100, 16'd7, 1'b0, 5'd19, mk("mod", 16'd2, 6'h00, 17));            collect(1'b1);
    issue(16'h1234, 16'h0000, 1'b0, 5'd18, mk("div_zero", 16'hFFFF, 6'h34, 1)); collect(1'b1);
`else
    issue(16'd100, 16'd7, 1'b0, 5'd18, mk("div_off", 16'd0, 6'h32, 1));         collect(1'b1);
    issue(16'd100, 16'd7, 1'b0, 5'd19, mk("mod_off", 16'd0, 6'h32, 1));         collect(1'b1);
    issue(16'h1234, 16'h0000, 1'b0, 5'd18, mk("div_zero_off", 16'd0, 6'h32, 1)); collect(1'b1);
`endif
    issue(16'h8001, 16'h0000, 1'b0, 5'd8, mk("shl_by0", 16'h8001, 6'h14, 1));   collect(1'b1);
    issue(16'h8001, 16'h0001, 1'b0, 5'd8, mk("shl_by1", 16'h0002, 6'h01, 1));   collect(1'b1);
    issue(16'h0001, 16'h0001, 1'b0, 5'd12, mk("ror_by1", 16'h8000, 6'h05, 1));  collect(1'b1);
    issue(16'hABCD, 16'h1234, 1'b1, 5'd25, mk("illegal", 16'h0000, 6'h32, 1));  collect(1'b1);

    // Backpressure: result must hold and a pulsed request must be dropped.
    issue(16'h1234, 16'h1111, 1'b0, 5'd0, mk("bp_add", 16'h2345, 6'h10, 1));
    collect(1'b0);
    for (int k = 0; k < 10; k++) begin
      if (k == 4) begin
        bus.in_valid = 1'b1; bus.A = 16'h0F0F; bus.B = 16'h0001; bus.F = 5'd0;
      end
      check("bp/in_ready_low", 64'(bus.in_ready), 64'(0));
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      check("bp/out_valid_held", 64'(bus.out_valid), 64'(1));
      check("bp/out_held", 64'(bus.Out), 64'(16'h2345));
      check("bp/status_held", 64'(bus.Status), 64'(6'h10));
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check("bp/in_ready_after", 64'(bus.in_ready), 64'(1));
    check("bp/out_valid_drop", 64'(bus.out_valid), 64'(0));
    repeat (3) begin
      @(posedge clk); #1;
      check("bp/not_queued", 64'(bus.out_valid), 64'(0));
    end

    // Reset during the fifth multiply iteration discards the partial result.
    issue(16'h00FF, 16'h0003, 1'b0, 5'd16, mk("mul_abort", 16'h02FD, 6'h00, 17));
    repeat (4) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort/out_valid", 64'(bus.out_valid), 64'(0));
    check("abort/out", 64'(bus.Out), 64'(0));
    check("abort/status", 64'(bus.Status), 64'(0));
    check("abort/in_ready_in_rst", 64'(bus.in_ready), 64'(0));
    rst = 1'b0;
    #1;
    check("abort/in_ready", 64'(bus.in_ready), 64'(1));
    sb.delete();
    issue(16'd2, 16'd3, 1'b0, 5'd0, mk("add_after_rst", 16'd5, 6'h10, 1));
    collect(1'b1);

    for (int i = 0; i < 64; i++) begin
      logic [W-1:0] ra, rb;
      logic [4:0]   rf;
      logic         rc;
      exp_t         x;
      ra = W'($urandom);
      rb = (i == 50 || i == 51) ? '0 : W'($urandom);
      rf = 5'(i % 32);
      rc = 1'($urandom);
      x = model(ra, rb, rc, rf);
      x.tag = $sformatf("rnd%0d_f%0d", i, rf);
      issue(ra, rb, rc, rf, x);
      collect(1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/alu_seq_unit.md
Name: alu_seq_unit

Overview:
- Parametrised, handshaked successor to the team's combinational ALU: same 5-bit F opcode space, Cin input and 6-bit Status.
- Adds registered outputs, valid/ready flow control, and iterative multiply and divide.
- Sits between an operand/opcode issue stage and a writeback stage; one operation in flight at a time.

Parameters:
- Width, 16, operand/result width in bits; legal range 4..64.
- SHAMT_W, $clog2(Width), shift-amount bits taken from B[SHAMT_W-1:0]; derived, do not override.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand/opcode valid.
- in_ready  output  1  unit accepts an operation; high only in IDLE and while rst is low.
- A  input  Width  operand A.
- B  input  Width  operand B.
- Cin  input  1  carry/borrow in.
- F  input  5  opcode.
- out_valid  output  1  Out/Status valid.
- out_ready  input  1  consumer accepts the result.
- Out  output  Width  registered result.
- Status  output  6  registered flags: [0] C, [1] Z, [2] N, [3] V, [4] P (even parity of Out), [5] E (error).

Behaviour:
- Reset (sync, active-high, 1 cycle): state=IDLE; out_valid=0; Out=0; Status=0; internal accumulators=0. in_ready is 0 while rst is high. Reset wins over every other event, including mid-iteration; the partial result is discarded.
- FSM states:
  - IDLE -> DONE when in_valid && in_ready and F is single-cycle.
  - IDLE -> CALC for F=16..19 with a non-zero divisor, or F=16..17.
  - CALC -> DONE after exactly Width iteration cycles.
  - DONE -> IDLE on out_valid && out_ready.
- A, B, Cin and F are latched on accept; input changes after accept have no effect.
- Latency, accept edge to out_valid=1:
  - 1 cycle for single-cycle ops.
  - Width+1 cycles for MUL/DIV.
- Throughput: one operation per 2 cycles minimum. There is no accept in the same cycle as result handoff.
- DONE holds Out/Status stable until handshake. in_valid during CALC or DONE is ignored and not queued.
- Single-cycle opcodes:
  - 0 ADD A+B.
  - 1 ADC A+B+Cin.
  - 2 SUB A-B.
  - 3 SBB A-B-Cin.
  - 4 AND; 5 OR; 6 XOR; 7 NOT A.
  - 8 SHL; 9 SHR (logical); 10 SAR; 11 ROL; 12 ROR, each by B[SHAMT_W-1:0].
  - 13 INC A; 14 DEC A; 15 PASS B.
- Iterative opcodes:
  - 16 MULLO: low Width bits of unsigned A*B, shift-add.
  - 17 MULHI: high Width bits of unsigned A*B.
  - 18 DIV: unsigned quotient, restoring division.
  - 19 MOD: unsigned remainder.
- Opcodes 20..31 are illegal: Out=0, E=1, other flags computed from Out. Latency 1.
- Flags:
  - Z, N (= Out[Width-1]) and P are always derived from the final Out.
  - Add/sub: C = carry out (for subtract, C=1 means borrow); V = signed two's-complement overflow.
  - Logic ops, PASS and MULHI: C=V=0.
  - Shifts/rotates: C = last bit shifted out, 0 when shift amount is 0; V=0.
  - MULLO: C=V=1 iff the high half is non-zero.
  - DIV/MOD: C=V=0.
- Divide by zero (B=0, F=18/19): no iteration, latency 1, E=1. DIV gives Out=all ones; MOD gives Out=A.
- All arithmetic wraps modulo 2^Width.
- E=0 for every legal, non-faulting operation.

Optional Feature:
- Macro: ALU_SEQ_DIV_EN.
- Defined: F=18/19 use the iterative restoring divider as above.
- Undefined: no divider logic is built. F=18/19 are treated as illegal: latency 1, Out=0, E=1. MUL is unaffected.

Test Plan:
- Width=16, ADD A=0xFFFF B=0x0001 -> Out=0x0000, C=1, Z=1, V=0, P=1; out_valid exactly 1 cycle after accept.
- SUB A=0x8000 B=0x0001 -> Out=0x7FFF, V=1, N=0, C=0. SBB A=0x0000 B=0x0000 Cin=1 -> Out=0xFFFF, C=1, N=1.
- MULLO A=0x0100 B=0x0100 -> Out=0x0000, C=V=1, Z=1; out_valid exactly 17 cycles after accept. MULHI with the same operands -> Out=0x0001.
- DIV 100/7 -> Out=14 and MOD 100/7 -> Out=2, each after 17 cycles. DIV A=0x1234 B=0 -> Out=0xFFFF, E=1, latency 1. With ALU_SEQ_DIV_EN undefined, DIV 100/7 -> Out=0, E=1.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> Out/Status unchanged, in_ready=0, and a pulsed in_valid with new operands is not accepted. Raising out_ready -> in_ready=1 on the next cycle.
- Reset mid-MULLO at iteration 5 -> the cycle after rst: out_valid=0, Out=0, Status=0; in_ready=1 once rst deasserts. The next ADD 2+3 -> Out=5.
